// File: rtl/outbuf_ctrl.sv
// Output buffer: stores whole engine result entries and streams each one
// out as W*PCK_TREE_XOR_UNITS_NUM packet beats over a valid/ready port.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   eng_rstn             sync active-low flush of pointers/count/FSM/flags
//   eng_outbuf_dout_reg  entry to store, packet [w][u]
//   eng_outbuf_wr_req    write request; outbuf_eng_wr_ack pulses when taken
//   outbuf_eng_full      no free entry
//   outbuf_empty         no stored entry
//   outbuf_cnt           stored entry count
//   outbuf_dout*         beat stream (val/rdy handshake, last on final beat)
//   outbuf_ovf_err       sticky: write requested while full
module outbuf_ctrl #(
    parameter int PACKET_LENGTH          = 32,
    parameter int W                      = 8,
    parameter int PCK_TREE_XOR_UNITS_NUM = 2,
    parameter int OUTBUF_DEPTH           = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              eng_rstn,
    input  logic [0:W-1][0:PCK_TREE_XOR_UNITS_NUM-1][PACKET_LENGTH-1:0]
                                              eng_outbuf_dout_reg,
    input  logic                              eng_outbuf_wr_req,
    output logic                              outbuf_eng_wr_ack,
    output logic                              outbuf_eng_full,
    output logic                              outbuf_empty,
    output logic [$clog2(OUTBUF_DEPTH):0]     outbuf_cnt,
    output logic [PACKET_LENGTH-1:0]          outbuf_dout,
    output logic                              outbuf_dout_val,
    input  logic                              outbuf_dout_rdy,
    output logic                              outbuf_dout_last,
    output logic                              outbuf_ovf_err
);

    localparam int P  = PCK_TREE_XOR_UNITS_NUM;
    localparam int PW = $clog2(OUTBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = (W > 1) ? $clog2(W) : 1;
    localparam int UW = (P > 1) ? $clog2(P) : 1;

    typedef logic [0:W-1][0:P-1][PACKET_LENGTH-1:0] entry_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;

    entry_t          mem_q [OUTBUF_DEPTH];
    rstate_t         state_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   w_q, w_nx;
    logic [UW-1:0]   u_q, u_nx;
    logic            ack_q, ovf_q, val_q, last_q;
    logic            full, wr_acc, wr_ovf, hs, pop, last_nx;

    assign full   = (cnt_q == CW'(OUTBUF_DEPTH));
    // Acceptance looks only at registered full: a same-cycle pop does not
    // free a slot for the incoming write.
    assign wr_acc = eng_rstn & eng_outbuf_wr_req & ~full;
    assign wr_ovf = eng_rstn & eng_outbuf_wr_req & full;
    assign hs     = val_q & outbuf_dout_rdy;
    assign pop    = hs & last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (!wr_acc && pop)
            cnt_d = cnt_q - CW'(1);
    end

    // Beat order walks w fastest, then u: beat = u*W + w.
    always_comb begin
        w_nx = w_q + WW'(1);
        u_nx = u_q;
        if (w_q == WW'(W - 1)) begin
            w_nx = '0;
            u_nx = u_q + UW'(1);
        end
    end

    assign last_nx = (w_nx == WW'(W - 1)) && (u_nx == UW'(P - 1));

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= eng_outbuf_dout_reg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= R_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            w_q      <= '0;
            u_q      <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            val_q    <= 1'b0;
            last_q   <= 1'b0;
        end else if (!eng_rstn) begin
            state_q  <= R_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            w_q      <= '0;
            u_q      <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
            val_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            ack_q <= wr_acc;
            cnt_q <= cnt_d;
            if (wr_ovf)
                ovf_q <= 1'b1;
            if (wr_acc)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            case (state_q)
                R_IDLE: begin
                    // cnt_d includes this edge's write, so a fresh entry
                    // is presented right after the edge that stores it.
                    if (cnt_d != '0) begin
                        state_q <= R_SEND;
                        val_q   <= 1'b1;
                        last_q  <= 1'(W * P == 1);
                        w_q     <= '0;
                        u_q     <= '0;
                    end
                end
                R_SEND: begin
                    if (hs && last_q) begin
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        w_q      <= '0;
                        u_q      <= '0;
                        if (cnt_d == '0) begin
                            state_q <= R_IDLE;
                            val_q   <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            last_q <= 1'(W * P == 1);
                        end
                    end else if (hs) begin
                        w_q    <= w_nx;
                        u_q    <= u_nx;
                        last_q <= last_nx;
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                    val_q   <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign outbuf_eng_wr_ack = ack_q;
    assign outbuf_eng_full   = full;
    assign outbuf_empty      = (cnt_q == '0);
    assign outbuf_cnt        = cnt_q;
    assign outbuf_dout_val   = val_q;
    assign outbuf_dout_last  = last_q;
    assign outbuf_ovf_err    = ovf_q;
    assign outbuf_dout       = val_q ? mem_q[rd_ptr_q][w_q][u_q] : '0;

endmodule

// File: tb/tb_outbuf_ctrl.sv
// Randomized bench for outbuf_ctrl against a queue-based entry/beat model.
// Entries are a FIFO; the head entry is read beat by beat as u*W + w.
module tb_outbuf_ctrl;

    localparam int PL    = 32;
    localparam int W     = 8;
    localparam int P     = 2;
    localparam int DEPTH = 4;
    localparam int NB    = W * P;

    typedef logic [0:W-1][0:P-1][PL-1:0] ent_t;

    logic                       clk = 1'b0;
    logic                       rstn;
    logic                       eng_rstn;
    ent_t                       din;
    logic                       wr_req;
    logic                       ack, full, empty, val, rdy, last, ovf;
    logic [$clog2(DEPTH):0]     cnt;
    logic [PL-1:0]              dout;

    outbuf_ctrl #(
        .PACKET_LENGTH(PL), .W(W),
        .PCK_TREE_XOR_UNITS_NUM(P), .OUTBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn),
        .eng_outbuf_dout_reg(din), .eng_outbuf_wr_req(wr_req),
        .outbuf_eng_wr_ack(ack), .outbuf_eng_full(full),
        .outbuf_empty(empty), .outbuf_cnt(cnt),
        .outbuf_dout(dout), .outbuf_dout_val(val),
        .outbuf_dout_rdy(rdy), .outbuf_dout_last(last),
        .outbuf_ovf_err(ovf)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    ent_t mq[$];
    int   mb;
    bit   m_ack, m_ovf;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic chk_outputs();
        ent_t e;
        chk("ack", 64'(ack), 64'(m_ack));
        chk("cnt", 64'(cnt), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("val", 64'(val), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            e = mq[0];
            chk("dout", 64'(dout), 64'(e[mb % W][mb / W]));
            chk("last", 64'(last), 64'(mb == NB - 1));
        end else begin
            chk("last_idle", 64'(last), 64'd0);
        end
    endtask

    task automatic chk_reset();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_val", 64'(val), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
    endtask

    task automatic model_clear();
        mq.delete();
        mb    = 0;
        m_ack = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Called just after a negedge: drive, update model, clock, check.
    task automatic step(input bit w, input bit r, input bit er);
        bit acc;
        wr_req   = w;
        rdy      = r;
        eng_rstn = er;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < P; j++)
                din[i][j] = $urandom;
        if (!er) begin
            model_clear();
        end else begin
            acc = w && (mq.size() < DEPTH);
            if (w && !acc) m_ovf = 1'b1;
            if (mq.size() != 0 && r) begin
                mb++;
                if (mb == NB) begin
                    void'(mq.pop_front());
                    mb = 0;
                end
            end
            if (acc) mq.push_back(din);
            m_ack = acc;
        end
        @(posedge clk);
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1 chk_reset();
        model_clear();
        @(negedge clk);
        chk_reset();
        rstn = 1'b1;
    endtask

    initial begin
        rstn     = 1'b0;
        eng_rstn = 1'b1;
        wr_req   = 1'b0;
        rdy      = 1'b0;
        din      = '0;
        model_clear();
        @(negedge clk);
        chk_reset();
        @(negedge clk);
        chk_reset();
        rstn = 1'b1;

        // Single entry, sink always ready.
        step(1, 1, 1);
        repeat (NB + 3) step(0, 1, 1);

        // Fill with sink stalled, then overflow, then drain.
        repeat (DEPTH) step(1, 0, 1);
        step(1, 0, 1);
        chk("ovf_set", 64'(ovf), 64'd1);
        repeat (DEPTH * NB + 2) step(0, 1, 1);

        // Write coinciding with last-beat pop at count 2.
        step(1, 1, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        repeat (NB - 1) step(0, 1, 1);
        step(1, 1, 1);
        chk("coinc_cnt", 64'(cnt), 64'd2);
        chk("coinc_ack", 64'(ack), 64'd1);
        repeat (2 * NB + 2) step(0, 1, 1);

        // Flush mid-entry at beat 5, then a new entry from beat 0.
        step(1, 1, 1);
        repeat (5) step(0, 1, 1);
        step(1, 1, 0);
        chk("flush_val", 64'(val), 64'd0);
        step(1, 1, 1);
        repeat (NB + 2) step(0, 1, 1);

        // Streaming with random stalls: exercises pointer wrap.
        repeat (400) step($urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) < 7, 1'b1);

        // Async reset mid-stream.
        repeat (3) step(1, 0, 1);
        repeat (3) step(0, 1, 1);
        async_reset();
        step(1, 1, 1);
        repeat (NB + 2) step(0, 1, 1);

        // Random mix including occasional flushes.
        repeat (2000) step($urandom_range(0, 2) != 0,
                           $urandom_range(0, 1) == 1,
                           $urandom_range(0, 49) != 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
